cellnet_fifo_relay: RTL and testbench
=====================================

CELLNET_FIFO_RELAY -- requirements
Module: cellnet_fifo_relay

Interface
REQ-001 The block SHALL have parameter ADDR_W, default `ADDRESS_SIZE, meaning the address width.
REQ-002 The block SHALL have parameter DAT_W, default `DATA_SIZE, meaning the data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of buffer entries; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port i_req, input, 1 bit: upstream (cellnet_source side) request.
REQ-007 The block SHALL have port i_addr, input, ADDR_W bits: upstream address.
REQ-008 The block SHALL have port i_dat, input, DAT_W bits: upstream data.
REQ-009 The block SHALL have port o_ack, output, 1 bit: upstream acknowledge.
REQ-010 The block SHALL have port o_req, output, 1 bit: downstream (cellnet_sink side) request.
REQ-011 The block SHALL have port o_addr, output, ADDR_W bits: downstream address.
REQ-012 The block SHALL have port o_dat, output, DAT_W bits: downstream data.
REQ-013 The block SHALL have port i_ack, input, 1 bit: downstream acknowledge.
REQ-014 The block SHALL have port o_count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-015 The block SHALL have port o_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 Both sides SHALL use a 4-phase handshake: req rise, ack rise, req fall, ack fall.
REQ-017 The upstream FSM SHALL have exactly two states, U_IDLE and U_ACK.
REQ-018 In U_IDLE, when i_req=1 and count<DEPTH at the edge, the FSM SHALL write {i_addr,i_dat} to the tail, advance the tail pointer, set o_ack=1, and go to U_ACK.
REQ-019 In U_IDLE, when i_req=1 and count=DEPTH, the FSM SHALL hold o_ack=0 and stay in U_IDLE; it SHALL capture on the first edge where count<DEPTH.
REQ-020 In U_ACK, when i_req=0, the FSM SHALL clear o_ack and go to U_IDLE; otherwise it SHALL hold.
REQ-021 The downstream FSM SHALL have exactly three states, D_IDLE, D_REQ and D_WAIT.
REQ-022 In D_IDLE with count>0, the FSM SHALL load o_addr/o_dat from the head entry, set o_req=1, and go to D_REQ.
REQ-023 In D_REQ with i_ack=1, the FSM SHALL clear o_req, advance the head pointer (pop), and go to D_WAIT.
REQ-024 In D_WAIT with i_ack=0, the FSM SHALL go to D_IDLE.
REQ-025 o_addr/o_dat SHALL change only on the D_IDLE->D_REQ transition and SHALL otherwise hold their last value.
REQ-026 Pointers SHALL be clog2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-027 On a push-only edge count SHALL increase by 1, on a pop-only edge it SHALL decrease by 1, and on a simultaneous push and pop it SHALL stay unchanged; o_count SHALL equal count.
REQ-028 A push SHALL require space at the start of the edge; a same-edge pop SHALL NOT admit a push when full.
REQ-029 The block SHALL never write when full and never pop when empty.
REQ-030 Latency: with the buffer empty, i_req sampled high at edge N SHALL give o_ack=1 after edge N and o_req=1 after edge N+1.
REQ-031 o_err SHALL be set, and stay set until reset, when i_ack=1 is sampled in D_IDLE, or when i_ack=0 is sampled in D_REQ after previously being 1 in D_REQ (impossible by the FSM, so it flags an RTL fault).
REQ-032 Entries SHALL be delivered in FIFO order without loss or duplication.

Reset
REQ-033 On i_rst_n=0, the block SHALL immediately force o_ack=0, o_req=0, o_addr=0, o_dat=0, o_count=0 and o_err=0, both FSMs to idle, and both pointers to 0.
REQ-034 A reset during any handshake SHALL discard all buffered entries.
REQ-035 Deassertion of reset SHALL take effect synchronously at the next edge.
REQ-036 Buffer storage SHALL need no reset.

Verification
REQ-037 Single transfer: addr=3, dat=0x5A, i_req=1 at edge 1 -> o_ack=1 after edge 1; o_req=1 with o_addr=3, o_dat=0x5A after edge 2; after i_ack, o_count returns to 0.
REQ-038 Fill: push 5 words (1..5) with i_ack held 0 -> o_count=4; the 5th i_req sees no o_ack until the first pop; output order SHALL be 1,2,3,4,5.
REQ-039 Simultaneous: count=2, push and pop on the same edge -> o_count stays 2; the data order is preserved.
REQ-040 Wrap: 10 back-to-back transfers with DEPTH=4 -> all 10 values appear in order; the pointers wrap twice.
REQ-041 Reset mid-operation: count=3, o_req=1, assert i_rst_n=0 -> all outputs 0 at once; after release, no stale data is emitted.
REQ-042 Violation: i_ack=1 while o_req=0 in D_IDLE -> o_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/cellnet_fifo_relay.sv
// Four-phase handshake relay with a DEPTH-entry FIFO between a cellnet source and sink.
// The upstream side accepts words into the buffer; the downstream side replays them in order.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_fifo_relay #(
    parameter int ADDR_W = `ADDRESS_SIZE,
    parameter int DAT_W  = `DATA_SIZE,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DAT_W-1:0]         i_dat,
    output logic                     o_ack,
    output logic                     o_req,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [DAT_W-1:0]         o_dat,
    input  logic                     i_ack,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DAT_W;

    typedef enum logic {U_IDLE, U_ACK} u_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} d_state_t;

    u_state_t         u_state_q, u_state_d;
    d_state_t         d_state_q, d_state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             err_q, err_d;
    logic             ack_seen_q, ack_seen_d;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;

    logic full, empty, push, pop, load;

    // Fullness is judged on the registered count, so a same-edge pop never makes room.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = (u_state_q == U_IDLE) && i_req && !full;
    assign pop   = (d_state_q == D_REQ) && i_ack && !empty;
    assign load  = (d_state_q == D_IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        u_state_d = u_state_q;
        case (u_state_q)
            U_IDLE:  if (push) u_state_d = U_ACK;
            U_ACK:   if (!i_req) u_state_d = U_IDLE;
            default: u_state_d = U_IDLE;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        case (d_state_q)
            D_IDLE: begin
                if (load) begin
                    d_state_d = D_REQ;
                    {addr_d, dat_d} = head;
                end
            end
            D_REQ:   if (i_ack) d_state_d = D_WAIT;
            D_WAIT:  if (!i_ack) d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ack_seen tracks an i_ack already taken in this D_REQ visit; a later low there means a broken FSM.
    always_comb begin
        ack_seen_d = ack_seen_q;
        if (load)
            ack_seen_d = 1'b0;
        else if (pop)
            ack_seen_d = 1'b1;
        err_d = err_q
              | ((d_state_q == D_IDLE) && i_ack)
              | ((d_state_q == D_REQ) && !i_ack && ack_seen_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            u_state_q  <= U_IDLE;
            d_state_q  <= D_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            dat_q      <= '0;
            err_q      <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            u_state_q  <= u_state_d;
            d_state_q  <= d_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            err_q      <= err_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {i_addr, i_dat};
    end

    assign o_ack   = (u_state_q == U_ACK);
    assign o_req   = (d_state_q == D_REQ);
    assign o_addr  = addr_q;
    assign o_dat   = dat_q;
    assign o_count = count_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_cellnet_fifo_relay.sv
// Directed bench for cellnet_fifo_relay: a scripted source and sink around a scoreboard queue.
module tb_cellnet_fifo_relay;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [7:0]  i_addr;
    logic [7:0]  i_dat;
    logic        o_ack;
    logic        o_req;
    logic [7:0]  o_addr;
    logic [7:0]  o_dat;
    logic        i_ack;
    logic [2:0]  o_count;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    bit src_en = 1'b1;
    bit sink_en = 1'b0;

    logic [15:0] src_q[$];
    logic [15:0] sb_q[$];

    cellnet_fifo_relay #(.ADDR_W(8), .DAT_W(8), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_dat   (i_dat),
        .o_ack   (o_ack),
        .o_req   (o_req),
        .o_addr  (o_addr),
        .o_dat   (o_dat),
        .i_ack   (i_ack),
        .o_count (o_count),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then let the scripted source and sink react.
    task automatic tick();
        logic [15:0] w;
        @(posedge clk);
        #1;
        if (i_req && o_ack) begin
            i_req = 1'b0;
        end else if (!i_req && !o_ack && src_en && src_q.size() > 0) begin
            w = src_q.pop_front();
            i_req  = 1'b1;
            i_addr = w[15:8];
            i_dat  = w[7:0];
            sb_q.push_back(w);
        end
        if (sink_en) begin
            if (o_req && !i_ack) begin
                if (sb_q.size() == 0) begin
                    check("req_without_data", {o_addr, o_dat}, 32'hDEAD_0000);
                end else begin
                    w = sb_q.pop_front();
                    check("delivery_order", {16'h0, o_addr, o_dat}, {16'h0, w});
                    delivered++;
                end
                i_ack = 1'b1;
            end else if (!o_req && i_ack) begin
                i_ack = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while (!(src_q.size() == 0 && sb_q.size() == 0 && !i_req && !o_ack && !o_req && !i_ack)
               && n < budget) begin
            tick();
            n++;
        end
        check(tag, (n < budget), 1);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   o_ack,   0);
        check({tag, "_req"},   o_req,   0);
        check({tag, "_addr"},  o_addr,  0);
        check({tag, "_dat"},   o_dat,   0);
        check({tag, "_count"}, o_count, 0);
        check({tag, "_err"},   o_err,   0);
    endtask

    initial begin
        logic [15:0] w;
        int n;
        int base;
        bit stale;

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; i_dat = '0; i_ack = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();

        // Single transfer with exact latency
        i_req = 1'b1; i_addr = 8'd3; i_dat = 8'h5A;
        @(posedge clk); #1;
        check("single_ack_edge1", o_ack, 1);
        check("single_req_edge1", o_req, 0);
        check("single_count_edge1", o_count, 1);
        i_req = 1'b0;
        @(posedge clk); #1;
        check("single_req_edge2", o_req, 1);
        check("single_addr", o_addr, 3);
        check("single_dat", o_dat, 8'h5A);
        i_ack = 1'b1;
        @(posedge clk); #1;
        check("single_count_after_pop", o_count, 0);
        check("single_req_dropped", o_req, 0);
        i_ack = 1'b0;
        tick(); tick();
        check("single_addr_hold", o_addr, 3);

        // Fill past capacity with the sink stalled
        sink_en = 1'b0;
        for (int k = 1; k <= 5; k++) src_q.push_back({8'(k), 8'(k * 17)});
        n = 0;
        while (!(o_count == 3'd4 && i_req && !o_ack && src_q.size() == 0) && n < 60) begin
            tick(); n++;
        end
        check("fill_reached", (n < 60), 1);
        check("fill_count", o_count, 4);
        repeat (5) tick();
        check("fill_no_ack_when_full", o_ack, 0);
        check("fill_count_held", o_count, 4);
        check("fill_head_req", o_req, 1);
        check("fill_head_addr", o_addr, 1);
        base = delivered;
        sink_en = 1'b1;
        run_until_idle("fill_drain_done", 200);
        check("fill_delivered", delivered - base, 5);
        check("fill_count_empty", o_count, 0);

        // Push and pop on the same edge at count=2
        sink_en = 1'b0;
        src_q.push_back(16'h0A_A1);
        src_q.push_back(16'h0B_B2);
        n = 0;
        while (!(o_count == 3'd2 && o_req && !i_req && !o_ack) && n < 40) begin
            tick(); n++;
        end
        check("simul_setup", (n < 40), 1);
        w = sb_q.pop_front();
        check("simul_head", {o_addr, o_dat}, w);
        delivered++;
        i_req = 1'b1; i_addr = 8'h0C; i_dat = 8'hC3;
        sb_q.push_back(16'h0C_C3);
        i_ack = 1'b1;
        @(posedge clk); #1;
        check("simul_count", o_count, 2);
        check("simul_ack", o_ack, 1);
        check("simul_req_dropped", o_req, 0);
        i_req = 1'b0;
        i_ack = 1'b0;
        sink_en = 1'b1;
        run_until_idle("simul_drain_done", 100);

        // Ten back-to-back transfers wrap the pointers twice
        base = delivered;
        for (int k = 0; k < 10; k++) src_q.push_back({8'(8'h20 + k), 8'(8'h90 + 3 * k)});
        run_until_idle("wrap_drain_done", 400);
        check("wrap_delivered", delivered - base, 10);
        check("wrap_err_clear", o_err, 0);

        // Reset while three entries are buffered and o_req is high
        sink_en = 1'b0;
        for (int k = 0; k < 3; k++) src_q.push_back({8'(8'h40 + k), 8'(8'hE0 + k)});
        n = 0;
        while (!(o_count == 3'd3 && o_req && !i_req && !o_ack) && n < 40) begin
            tick(); n++;
        end
        check("midreset_setup", (n < 40), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        src_q.delete();
        i_req = 1'b0;
        i_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sink_en = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            tick();
            if (o_req) stale = 1'b1;
        end
        check("midreset_no_stale", stale, 0);
        check("midreset_count", o_count, 0);
        base = delivered;
        src_q.push_back(16'h77_3C);
        run_until_idle("midreset_after_done", 50);
        check("midreset_after_delivered", delivered - base, 1);

        // Protocol violation: ack while idle
        sink_en = 1'b0;
        check("viol_err_before", o_err, 0);
        i_ack = 1'b1;
        @(posedge clk); #1;
        check("viol_err_set", o_err, 1);
        i_ack = 1'b0;
        repeat (3) tick();
        check("viol_err_sticky", o_err, 1);
        rst_n = 1'b0;
        #1;
        check("viol_err_reset", o_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
